// File: rtl/fbw_pkg.sv
// Shared definitions for the frame-buffer writer: frame geometry, pixel type, FSM states.
package fbw_pkg;

    localparam int unsigned H_PIX     = 320;
    localparam int unsigned V_PIX     = 240;
    localparam int unsigned FRAME_PIX = H_PIX * V_PIX;
    localparam int unsigned ADDR_W    = 17;
    localparam int unsigned DATA_W    = 12;

    // Pixel word {R4,G4,B4}
    typedef logic [DATA_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_STREAM = 2'd2
    } fbw_state_e;

    // Checkerboard colour: base colour on even cells, its inverse on odd cells
    function automatic pixel_t checker_pix(pixel_t base, logic odd_cell);
        return odd_cell ? ~base : base;
    endfunction

endpackage

// File: rtl/fbw_raster_cnt.sv
// Raster position counters: x/y and the linear address y*H_PIX+x kept as a running count.
module fbw_raster_cnt #(
    parameter int unsigned H_PIX  = 320,
    parameter int unsigned V_PIX  = 240,
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned X_W    = $clog2(H_PIX),
    parameter int unsigned Y_W    = $clog2(V_PIX)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic x_end;
    logic y_end;

    assign x_end = (x == X_W'(H_PIX - 1));
    assign y_end = (y == Y_W'(V_PIX - 1));
    assign last  = (addr == ADDR_W'(H_PIX * V_PIX - 1));

    // Advance x, wrap into y at end of line; address runs alongside without a multiply
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (clr) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (inc) begin
            if (x_end) begin
                x <= '0;
                y <= y_end ? '0 : y + Y_W'(1);
            end else begin
                x <= x + X_W'(1);
            end
            addr <= last ? '0 : addr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/frame_buf_writer.sv
// Write-side engine for the display frame buffer: constant/checker fill (CLEAR) or
// valid/ready pixel stream (STREAM), one BRAM port-A write per pixel.
// Build option: FBW_CHECKER_EN makes CLEAR paint an 8x8 checkerboard of clear_color / ~clear_color.
module frame_buf_writer
    import fbw_pkg::*;
#(
    parameter int unsigned H_PIX  = fbw_pkg::H_PIX,
    parameter int unsigned V_PIX  = fbw_pkg::V_PIX,
    parameter int unsigned ADDR_W = fbw_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_clear,
    input  pixel_t            clear_color,
    input  logic              start_stream,
    input  logic              abort,
    input  logic              pix_valid,
    input  pixel_t            pix_data,
    output logic              pix_ready,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output pixel_t            dina,
    output logic              busy,
    output logic              done
);

    localparam int unsigned X_W = $clog2(H_PIX);
    localparam int unsigned Y_W = $clog2(V_PIX);

    fbw_state_e        state;
    fbw_state_e        state_nxt;
    logic              fin;
    logic              fin_nxt;
    logic              ready_q;
    logic              done_nxt;
    logic              wr_en;
    pixel_t            wr_data;
    pixel_t            color_q;
    pixel_t            fill;
    logic              cnt_clr;
    logic              cnt_inc;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [ADDR_W-1:0] addr;
    logic              last;

    fbw_raster_cnt #(
        .H_PIX  (H_PIX),
        .V_PIX  (V_PIX),
        .ADDR_W (ADDR_W),
        .X_W    (X_W),
        .Y_W    (Y_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .x    (x),
        .y    (y),
        .addr (addr),
        .last (last)
    );

`ifdef FBW_CHECKER_EN
    // Cell parity from bit 3 of each coordinate gives 8x8 squares
    assign fill = checker_pix(color_q, x[3] ^ y[3]);
`else
    logic unused_xy;
    assign unused_xy = ^{x, y};
    assign fill      = color_q;
`endif

    // Abort withdraws ready in the same cycle so no pixel is taken while leaving
    assign pix_ready = ready_q && !abort;

    // Next-state, counter control and write issue
    always_comb begin
        state_nxt = state;
        fin_nxt   = fin;
        done_nxt  = 1'b0;
        wr_en     = 1'b0;
        wr_data   = fill;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start_clear) begin
                    state_nxt = ST_CLEAR;
                    cnt_clr   = 1'b1;
                    fin_nxt   = 1'b0;
                end else if (start_stream) begin
                    state_nxt = ST_STREAM;
                    cnt_clr   = 1'b1;
                    fin_nxt   = 1'b0;
                end
            end
            ST_CLEAR, ST_STREAM: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    fin_nxt   = 1'b0;
                end else if (fin) begin
                    // Final write is on the port this cycle; report completion next
                    state_nxt = ST_IDLE;
                    fin_nxt   = 1'b0;
                    done_nxt  = 1'b1;
                end else if (state == ST_CLEAR || pix_valid) begin
                    wr_en   = 1'b1;
                    wr_data = (state == ST_CLEAR) ? fill : pix_data;
                    cnt_inc = 1'b1;
                    fin_nxt = last;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                fin_nxt   = 1'b0;
            end
        endcase
    end

    // State, handshake and BRAM port registers; address/data hold between writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            fin     <= 1'b0;
            ready_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wea     <= 1'b0;
            addra   <= '0;
            dina    <= '0;
            color_q <= '0;
        end else begin
            state   <= state_nxt;
            fin     <= fin_nxt;
            ready_q <= (state_nxt == ST_STREAM) && !fin_nxt;
            busy    <= (state_nxt != ST_IDLE);
            done    <= done_nxt;
            wea     <= wr_en;
            if (wr_en) begin
                addra <= addr;
                dina  <= wr_data;
            end
            if (state == ST_IDLE && start_clear) begin
                color_q <= clear_color;
            end
        end
    end

endmodule

// File: tb/tb_frame_buf_writer.sv
// Self-checking bench for frame_buf_writer on a reduced 40x24 frame.
module tb_frame_buf_writer;

    localparam int TH = 40;
    localparam int TV = 24;
    localparam int TF = TH * TV;

    logic        clk;
    logic        rst;
    logic        start_clear;
    logic [11:0] clear_color;
    logic        start_stream;
    logic        abort;
    logic        pix_valid;
    logic [11:0] pix_data;
    logic        pix_ready;
    logic        wea;
    logic [16:0] addra;
    logic [11:0] dina;
    logic        busy;
    logic        done;

    frame_buf_writer #(
        .H_PIX  (TH),
        .V_PIX  (TV),
        .ADDR_W (17)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_clear  (start_clear),
        .clear_color  (clear_color),
        .start_stream (start_stream),
        .abort        (abort),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .pix_ready    (pix_ready),
        .wea          (wea),
        .addra        (addra),
        .dina         (dina),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Colour a full-frame CLEAR must leave at linear address n
    function automatic logic [11:0] fill(input int n, input logic [11:0] c);
        int px;
        int py;
        px = n % TH;
        py = n / TH;
`ifdef FBW_CHECKER_EN
        if (((px / 8) % 2) != ((py / 8) % 2)) return ~c;
`endif
        return c;
    endfunction

    // Reference model: writes issued so far, mode, and the port values they imply
    int          m_mode;
    int          m_n;
    logic [11:0] m_col;
    logic        e_wea;
    logic        e_done;
    logic        e_busy;
    logic        e_rdy;
    logic [16:0] e_addra;
    logic [11:0] e_dina;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode  <= 0;
            m_n     <= 0;
            m_col   <= '0;
            e_wea   <= 1'b0;
            e_done  <= 1'b0;
            e_busy  <= 1'b0;
            e_rdy   <= 1'b0;
            e_addra <= '0;
            e_dina  <= '0;
        end else begin
            e_wea  <= 1'b0;
            e_done <= 1'b0;
            if (m_mode == 0) begin
                if (start_clear) begin
                    m_mode <= 1; m_n <= 0; m_col <= clear_color;
                    e_busy <= 1'b1; e_rdy <= 1'b0;
                end else if (start_stream) begin
                    m_mode <= 2; m_n <= 0;
                    e_busy <= 1'b1; e_rdy <= 1'b1;
                end
            end else if (abort) begin
                m_mode <= 0; e_busy <= 1'b0; e_rdy <= 1'b0;
            end else if (m_n == TF) begin
                m_mode <= 0; e_busy <= 1'b0; e_rdy <= 1'b0; e_done <= 1'b1;
            end else if (m_mode == 1 || pix_valid) begin
                e_wea   <= 1'b1;
                e_addra <= 17'(m_n);
                e_dina  <= (m_mode == 1) ? fill(m_n, m_col) : pix_data;
                m_n     <= m_n + 1;
                if (m_n + 1 == TF) e_rdy <= 1'b0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (rst) begin
            chk("wea",       32'(wea),       32'(e_wea));
            chk("addra",     32'(addra),     32'(e_addra));
            chk("dina",      32'(dina),      32'(e_dina));
            chk("busy",      32'(busy),      32'(e_busy));
            chk("done",      32'(done),      32'(e_done));
            chk("pix_ready", 32'(pix_ready), 32'(e_rdy && !abort));
        end
    end

    // Shadow BRAM and event counters
    logic [11:0] mem [0:TF-1];
    int wr_cnt;
    int done_cnt;
    int rdy_cnt;
    int first_addr;

    always @(negedge clk) begin
        if (rst) begin
            if (wea) begin
                if (int'(addra) < TF) mem[int'(addra)] = dina;
                if (wr_cnt == 0) first_addr = int'(addra);
                wr_cnt++;
            end
            if (done) done_cnt++;
            if (pix_ready) rdy_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_stats();
        wr_cnt = 0; done_cnt = 0; rdy_cnt = 0; first_addr = -1;
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        while (done_cnt == 0 && c < budget) begin
            step();
            c++;
        end
        chk("done_timeout", 32'(done_cnt > 0), 32'd1);
        repeat (4) step();
    endtask

    task automatic pulse_clear(input logic [11:0] col);
        start_clear = 1'b1; clear_color = col;
        step();
        start_clear = 1'b0; clear_color = 12'h000;
    endtask

    // Stream driver; abort_at >= 0 aborts right after that many pixels are accepted
    task automatic run_stream(input bit toggle, input int abort_at, input int budget);
        int  n;
        int  cyc;
        bit  acc;
        bit  ab;
        n = 0; cyc = 0; ab = 1'b0;
        start_stream = 1'b1;
        step();
        start_stream = 1'b0;
        pix_valid = 1'b1;
        pix_data  = toggle ? 12'(n) : (12'(n) ^ 12'h5A5);
        while (cyc < budget) begin
            @(negedge clk);
            if (ab) chk("abort_ready", 32'(pix_ready), 32'd0);
            acc = pix_valid && pix_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) n++;
            if (ab) begin
                abort = 1'b0;
                break;
            end
            if (done_cnt > 0) break;
            if (abort_at >= 0 && n == abort_at) begin
                abort = 1'b1;
                ab = 1'b1;
            end
            pix_valid = toggle ? ~pix_valid : 1'b1;
            pix_data  = toggle ? 12'(n) : (12'(n) ^ 12'h5A5);
        end
        if (cyc >= budget) chk("stream_timeout", 32'(cyc), 32'(budget - 1));
        // Surplus pixels offered after the frame must not be consumed
        pix_valid = 1'b1;
        repeat (8) step();
        pix_valid = 1'b0;
    endtask

    initial begin
        int bad;
        rst = 1'b0; start_clear = 1'b0; clear_color = '0; start_stream = 1'b0;
        abort = 1'b0; pix_valid = 1'b0; pix_data = '0;
        clr_stats();
        repeat (3) step();
        chk("rst_wea",   32'(wea),       32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_addra", 32'(addra),     32'd0);
        chk("rst_dina",  32'(dina),      32'd0);
        chk("rst_ready", 32'(pix_ready), 32'd0);
        rst = 1'b1;
        repeat (2) step();

        // 1: full CLEAR with F00
        clr_stats();
        pulse_clear(12'hF00);
        wait_done(TF + 20);
        chk("t1_writes", 32'(wr_cnt), 32'(TF));
        chk("t1_done_n", 32'(done_cnt), 32'd1);
        chk("t1_busy",   32'(busy), 32'd0);
        chk("t1_mem0",   32'(mem[0]), 32'h0F00);
        chk("t1_memlast", 32'(mem[TF-1]), 32'h0F00);
        bad = 0;
        for (int i = 0; i < TF; i++) if (mem[i] !== fill(i, 12'hF00)) bad++;
        chk("t1_mem_all", 32'(bad), 32'd0);

        // 2: STREAM with valid toggling, data = address
        clr_stats();
        run_stream(1'b1, -1, 3 * TF);
        chk("t2_writes", 32'(wr_cnt), 32'(TF));
        chk("t2_done_n", 32'(done_cnt), 32'd1);
        chk("t2_mem5",   32'(mem[5]), 32'h005);
        chk("t2_memlast", 32'(mem[TF-1]), 32'h3BF);
        bad = 0;
        for (int i = 0; i < TF; i++) if (mem[i] !== 12'(i)) bad++;
        chk("t2_mem_all", 32'(bad), 32'd0);

        // 3: simultaneous starts pick CLEAR; start_stream during CLEAR ignored
        clr_stats();
        start_clear = 1'b1; start_stream = 1'b1; clear_color = 12'h0AB;
        step();
        start_clear = 1'b0; start_stream = 1'b0; clear_color = 12'h000;
        repeat (100) step();
        start_stream = 1'b1;
        step();
        start_stream = 1'b0;
        wait_done(TF + 20);
        chk("t3_writes", 32'(wr_cnt), 32'(TF));
        chk("t3_ready_n", 32'(rdy_cnt), 32'd0);
        chk("t3_mem1",   32'(mem[1]), 32'h0AB);
        repeat (10) step();
        chk("t3_busy",   32'(busy), 32'd0);

        // 4: abort after 300 accepted pixels
        clr_stats();
        run_stream(1'b0, 300, 2 * TF);
        repeat (40) step();
        chk("t4_writes", 32'(wr_cnt), 32'd300);
        chk("t4_done_n", 32'(done_cnt), 32'd0);
        chk("t4_mem299", 32'(mem[299]), 32'h48E);
        chk("t4_busy",   32'(busy), 32'd0);

        // 5: asynchronous reset in the middle of a CLEAR, then a fresh CLEAR
        clr_stats();
        pulse_clear(12'h123);
        begin
            int c;
            c = 0;
            while (wr_cnt < 500 && c < 2 * TF) begin
                step();
                c++;
            end
        end
        chk("t5_reached", 32'(wr_cnt), 32'd500);
        #2 rst = 1'b0;
        #1;
        chk("t5_wea",   32'(wea),       32'd0);
        chk("t5_busy",  32'(busy),      32'd0);
        chk("t5_done",  32'(done),      32'd0);
        chk("t5_addra", 32'(addra),     32'd0);
        chk("t5_dina",  32'(dina),      32'd0);
        chk("t5_ready", 32'(pix_ready), 32'd0);
        repeat (2) step();
        rst = 1'b1;
        repeat (2) step();
        chk("t5_no_done", 32'(done_cnt), 32'd0);
        clr_stats();
        pulse_clear(12'h456);
        wait_done(TF + 20);
        chk("t5_first_addr", 32'(first_addr), 32'd0);
        chk("t5_writes", 32'(wr_cnt), 32'(TF));

        // 6: fill pattern at cell corners with 0F0
        clr_stats();
        pulse_clear(12'h0F0);
        wait_done(TF + 20);
        chk("t6_mem0", 32'(mem[0]), 32'h0F0);
`ifdef FBW_CHECKER_EN
        chk("t6_mem8",   32'(mem[8]),   32'hF0F);
        chk("t6_mem320", 32'(mem[320]), 32'hF0F);
        chk("t6_mem328", 32'(mem[328]), 32'h0F0);
`else
        chk("t6_mem8",   32'(mem[8]),   32'h0F0);
        chk("t6_mem320", 32'(mem[320]), 32'h0F0);
        chk("t6_mem328", 32'(mem[328]), 32'h0F0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
